// File: rtl/wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_pkg
// Description : Shared widths, constants and types for the write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_arbiter_pkg;

    localparam int REG_W         = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int NUM_REGS      = 32;
    localparam int LD_FIFO_DEPTH = 2;

    localparam logic [REG_W-1:0]      ZERO_WORD     = '0;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG_ADDR = '0;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [REG_W-1:0]      data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        SRC_NONE   = 2'd0,
        SRC_ALU    = 2'd1,
        SRC_FIFO   = 2'd2,
        SRC_BYPASS = 2'd3
    } wb_src_e;

    function automatic logic is_load_src(input wb_src_e src);
        return (src == SRC_FIFO) || (src == SRC_BYPASS);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Synchronous load-result FIFO carrying {addr,data}; holds on !rdy.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH = LD_FIFO_DEPTH
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      rdy_i,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t din_i,
    output wb_entry_t head_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    wb_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign do_push = rdy_i && push_i && !full_o;
    assign do_pop  = rdy_i && pop_i && !empty_o;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (PTR_W + 1)'(do_push) - (PTR_W + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= din_i;
    end

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Write-port arbiter (ALU > FIFO head > load bypass) plus load scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = LD_FIFO_DEPTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rdy_i,
    input  logic                  alu_valid_i,
    input  logic [REG_ADDR_W-1:0] alu_addr_i,
    input  logic [REG_W-1:0]      alu_data_i,
    input  logic                  ld_valid_i,
    output logic                  ld_ready_o,
    input  logic [REG_ADDR_W-1:0] ld_addr_i,
    input  logic [REG_W-1:0]      ld_data_i,
    input  logic                  issue_valid_i,
    input  logic [REG_ADDR_W-1:0] issue_addr_i,
    input  logic [REG_ADDR_W-1:0] q1_addr_i,
    input  logic [REG_ADDR_W-1:0] q2_addr_i,
    input  logic [REG_ADDR_W-1:0] qd_addr_i,
    output logic                  q1_busy_o,
    output logic                  q2_busy_o,
    output logic                  qd_busy_o,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [REG_W-1:0]      w_data_o
);

    wb_entry_t             fifo_head;
    wb_entry_t             ld_entry;
    wb_entry_t             sel_entry;
    wb_src_e               sel_src;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  ld_acc;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic [NUM_REGS-1:0]   busy_d;
    logic [NUM_REGS-1:0]   busy_q;
    logic                  w_enable_q;
    logic [REG_ADDR_W-1:0] w_addr_q;
    logic [REG_W-1:0]      w_data_q;

    assign ld_entry.addr = ld_addr_i;
    assign ld_entry.data = ld_data_i;
    assign ld_ready_o    = rdy_i && !rst_i && !fifo_full;
    assign ld_acc        = ld_valid_i && ld_ready_o;

    always_comb begin
        sel_src   = SRC_NONE;
        sel_entry = '{addr: ZERO_REG_ADDR, data: ZERO_WORD};
        fifo_push = 1'b0;
        fifo_pop  = 1'b0;
        if (alu_valid_i) begin
            sel_src        = SRC_ALU;
            sel_entry.addr = alu_addr_i;
            sel_entry.data = alu_data_i;
            fifo_push      = ld_acc;
        end else if (!fifo_empty) begin
            sel_src   = SRC_FIFO;
            sel_entry = fifo_head;
            fifo_pop  = 1'b1;
            fifo_push = ld_acc;
        end else if (ld_acc) begin
            sel_src   = SRC_BYPASS;
            sel_entry = ld_entry;
        end
    end

    // Clear before set so a re-issue to the draining register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (is_load_src(sel_src)) busy_d[sel_entry.addr] = 1'b0;
        if (issue_valid_i && (issue_addr_i != ZERO_REG_ADDR)) busy_d[issue_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= '0;
            w_enable_q <= 1'b0;
            w_addr_q   <= ZERO_REG_ADDR;
            w_data_q   <= ZERO_WORD;
        end else if (rdy_i) begin
            busy_q     <= busy_d;
            w_enable_q <= (sel_src != SRC_NONE) && (sel_entry.addr != ZERO_REG_ADDR);
            if (sel_src != SRC_NONE) begin
                w_addr_q <= sel_entry.addr;
                w_data_q <= sel_entry.data;
            end
        end
    end

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .rdy_i   (rdy_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (ld_entry),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign q1_busy_o  = busy_q[q1_addr_i];
    assign q2_busy_o  = busy_q[q2_addr_i];
    assign qd_busy_o  = busy_q[qd_addr_i];
    assign w_enable_o = w_enable_q;
    assign w_addr_o   = w_addr_q;
    assign w_data_o   = w_data_q;

endmodule
`default_nettype wire
